lz77_search_ctrl: RTL and testbench



---
 rtl/lz77_pkg.sv | 19 +
 rtl/lz77_match_len.sv | 38 +++
 rtl/lz77_search_ctrl.sv | 149 ++++++++++++++
 tb/tb_lz77_search_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lz77_pkg.sv
// Shared sizing, FSM state encoding and token layout for the LZ77 search controller.
package lz77_pkg;
  localparam int SEARCH_LEN = 9;                 // window depth, offsets 0..SEARCH_LEN-1
  localparam int LOOK_LEN   = 8;                 // lookahead depth, max match LOOK_LEN-1
  localparam int OFF_W      = 4;
  localparam int LEN_W      = 3;
  localparam int CNT_W      = 4;                 // search_cnt / look_cnt width
  localparam int LA_W       = $clog2(LOOK_LEN);  // lookahead index width

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SEARCH, S_EMIT, S_SHIFT, S_DONE
  } state_t;

  typedef struct packed {
    logic [OFF_W-1:0] offset;
    logic [LEN_W-1:0] len;
    logic [7:0]       ch;
  } tok_t;
endpackage

// File: rtl/lz77_match_len.sv
// Combinational match length for one candidate offset.
// Offset o starts at window[o] (window[0] is the newest character) and walks
// forward in time; once it passes window[0] it continues into the lookahead,
// which is how overlapping matches are found. Ineligible offsets give 0.
module lz77_match_len
  import lz77_pkg::*;
(
  input  logic [SEARCH_LEN-1:0][7:0] win,
  input  logic [LOOK_LEN-1:0][7:0]   look,
  input  logic [CNT_W-1:0]           search_cnt,
  input  logic [CNT_W-1:0]           look_cnt,
  input  logic [LEN_W-1:0]           cap,
  input  logic [OFF_W-1:0]           offset,
  output logic [LEN_W-1:0]           len
);
  logic             run;
  logic [7:0]       src;
  logic [OFF_W-1:0] widx;
  logic [LA_W-1:0]  lidx;

  // Count leading matching characters, stopping at the first miss or the cap.
  always_comb begin
    len  = '0;
    run  = (offset < search_cnt);
    src  = '0;
    widx = '0;
    lidx = '0;
    for (int k = 0; k < LOOK_LEN-1; k++) begin
      widx = offset - OFF_W'(k);
      lidx = LA_W'(k) - LA_W'(offset) - LA_W'(1);
      src  = (OFF_W'(k) <= offset) ? win[widx] : look[lidx];
      if (run && (LEN_W'(k) < cap) && (CNT_W'(k) < look_cnt) && (src == look[k]))
        len = len + LEN_W'(1);
      else
        run = 1'b0;
    end
  end
endmodule

// File: rtl/lz77_search_ctrl.sv
// LZ77 search controller: fills the lookahead, scans one offset per cycle,
// emits (offset, len, char) tokens and slides the window len+1 positions.
// Build option: define LZ77_EARLY_EXIT_EN to leave SEARCH as soon as the best
// match reaches the length cap (same tokens, fewer cycles).
module lz77_search_ctrl
  import lz77_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  output logic             in_ready,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [OFF_W-1:0] tok_offset,
  output logic [LEN_W-1:0] tok_len,
  output logic [7:0]       tok_char,
  output logic             done
);
  state_t                   state, state_nxt;
  logic [SEARCH_LEN-1:0][7:0] win;
  logic [LOOK_LEN-1:0][7:0]   look;
  logic [CNT_W-1:0]         search_cnt, look_cnt, look_after, lc_m1, shift_left;
  logic                     ended;
  logic [OFF_W-1:0]         srch_idx, best_off, nb_off;
  logic [LEN_W-1:0]         best_len, nb_len, cand_len, cap;
  logic                     accept, search_last, shift_step, shift_fin;
  tok_t                     tok_q;

  lz77_match_len u_match (
    .win        (win),
    .look       (look),
    .search_cnt (search_cnt),
    .look_cnt   (look_cnt),
    .cap        (cap),
    .offset     (srch_idx),
    .len        (cand_len)
  );

  assign lc_m1  = look_cnt - CNT_W'(1);
  assign cap    = (lc_m1 > CNT_W'(LOOK_LEN-1)) ? LEN_W'(LOOK_LEN-1) : lc_m1[LEN_W-1:0];
  // strict greater-than keeps the smallest offset on ties
  assign nb_len = (cand_len > best_len) ? cand_len : best_len;
  assign nb_off = (cand_len > best_len) ? srch_idx : best_off;
`ifdef LZ77_EARLY_EXIT_EN
  assign search_last = (srch_idx == OFF_W'(SEARCH_LEN-1)) || (nb_len == cap);
`else
  assign search_last = (srch_idx == OFF_W'(SEARCH_LEN-1));
`endif
  assign accept     = in_valid && in_ready;
  // a refill shift needs a character; a drain shift does not
  assign shift_step = (state == S_SHIFT) && (ended || in_valid);
  assign shift_fin  = shift_step && (shift_left == CNT_W'(1));
  assign look_after = ended ? look_cnt - CNT_W'(1) : look_cnt;

  assign tok_offset = tok_q.offset;
  assign tok_len    = tok_q.len;
  assign tok_char   = tok_q.ch;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    tok_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_FILL;
      S_FILL: begin
        in_ready = (look_cnt < CNT_W'(LOOK_LEN)) && !ended;
        if ((look_cnt == CNT_W'(LOOK_LEN)) || ended) state_nxt = S_SEARCH;
      end
      S_SEARCH: if (search_last) state_nxt = S_EMIT;
      S_EMIT: begin
        tok_valid = 1'b1;
        if (tok_ready) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        in_ready = !ended;
        if (shift_fin) state_nxt = (look_after == '0) ? S_DONE : S_SEARCH;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Buffers, counters, best-match tracking and the token register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      win        <= '0;
      look       <= '0;
      search_cnt <= '0;
      look_cnt   <= '0;
      ended      <= 1'b0;
      srch_idx   <= '0;
      best_off   <= '0;
      best_len   <= '0;
      shift_left <= '0;
      tok_q      <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          search_cnt <= '0;
          look_cnt   <= '0;
          ended      <= 1'b0;
        end
        S_FILL: if (accept) begin
          look[look_cnt[LA_W-1:0]] <= in_char;
          look_cnt <= look_cnt + CNT_W'(1);
          if (in_last) ended <= 1'b1;
        end
        S_SEARCH: begin
          srch_idx <= srch_idx + OFF_W'(1);
          best_off <= nb_off;
          best_len <= nb_len;
          if (search_last) begin
            tok_q      <= '{offset: nb_off, len: nb_len, ch: look[nb_len]};
            shift_left <= CNT_W'(nb_len) + CNT_W'(1);
          end
        end
        S_SHIFT: if (shift_step) begin
          win        <= {win[SEARCH_LEN-2:0], look[0]};
          search_cnt <= (search_cnt == CNT_W'(SEARCH_LEN)) ? search_cnt : search_cnt + CNT_W'(1);
          look       <= {(ended ? 8'h00 : in_char), look[LOOK_LEN-1:1]};
          look_cnt   <= look_after;
          shift_left <= shift_left - CNT_W'(1);
          if (!ended && in_last) ended <= 1'b1;
        end
        default: ;
      endcase
      // fresh scan on every entry to SEARCH
      if ((state != S_SEARCH) && (state_nxt == S_SEARCH)) begin
        srch_idx <= '0;
        best_off <= '0;
        best_len <= '0;
      end
    end
  end
endmodule

// File: tb/tb_lz77_search_ctrl.sv
// Directed bench for lz77_search_ctrl: character source queue, token scoreboard.
module tb_lz77_search_ctrl;
  import lz77_pkg::*;

  logic             clk = 1'b0;
  logic             reset, start, in_valid, in_last, in_ready;
  logic             tok_valid, tok_ready, done;
  logic [7:0]       in_char, tok_char;
  logic [OFF_W-1:0] tok_offset;
  logic [LEN_W-1:0] tok_len;

  always #5 clk = ~clk;

  lz77_search_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_char(in_char), .in_last(in_last), .in_ready(in_ready),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_offset(tok_offset), .tok_len(tok_len), .tok_char(tok_char),
    .done(done)
  );

`ifdef LZ77_EARLY_EXIT_EN
  localparam int EXP_GAP2 = 3;   // SHIFT + 1 SEARCH cycle
`else
  localparam int EXP_GAP2 = 11;  // SHIFT + 9 SEARCH cycles
`endif

  logic [8:0]  src_q[$];   // {last, char}
  logic [14:0] exp_q[$];   // {offset, len, char}
  int          gaps[$];
  int passed = 0, total = 0, fails = 0;
  int cyc = 0, hs_cyc = 0, tok_idx = 0, done_cnt = 0;
  int stall_on = -1, stall_rem = 0, stall_seen = 0;
  bit tv_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] tk(input int o, input int l, input logic [7:0] c);
    return {OFF_W'(o), LEN_W'(l), c};
  endfunction

  task automatic load(input string s);
    logic [8:0] e;
    for (int i = 0; i < s.len(); i++) begin
      e = {(i == s.len()-1), s[i]};
      src_q.push_back(e);
    end
  endtask

  task automatic drive_inputs();
    if (src_q.size() > 0) begin
      in_valid = 1'b1;
      {in_last, in_char} = src_q[0];
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_char  = 8'h00;
    end
  endtask

  // One clock: observe at negedge, then update inputs just after posedge.
  task automatic tick();
    bit acc;
    @(negedge clk);
    cyc++;
    acc = in_valid && in_ready;
    if (tok_valid && !tv_prev) gaps.push_back(cyc - hs_cyc);
    tv_prev = tok_valid;
    if (tok_valid && !tok_ready) begin
      stall_seen++;
      if (stall_rem > 0) stall_rem--;
      chk("stall_in_ready", in_ready, 0);
      if (exp_q.size() > 0) chk("stall_tok_hold", {tok_offset, tok_len, tok_char}, exp_q[0]);
    end
    if (tok_valid && tok_ready) begin
      if (exp_q.size() > 0)
        chk($sformatf("tok%0d", tok_idx), {tok_offset, tok_len, tok_char}, exp_q.pop_front());
      else
        chk("tok_expected", exp_q.size(), 1);
      tok_idx++;
      hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      chk("done_after_last_tok", exp_q.size(), 0);
    end
    @(posedge clk);
    #1;
    if (acc) void'(src_q.pop_front());
    drive_inputs();
    tok_ready = !((tok_idx == stall_on) && (stall_rem > 0));
  endtask

  task automatic start_string();
    gaps.delete();
    tok_idx  = 0;
    done_cnt = 0;
    hs_cyc   = cyc;
    drive_inputs();
    tick();
    chk("idle_in_ready", in_ready, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    chk({tag, "_done_seen"}, done_cnt, 1);
    tick();
    tick();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_tokens_left"}, exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"},   in_ready, 0);
    chk({tag, "_tok_valid"},  tok_valid, 0);
    chk({tag, "_done"},       done, 0);
    chk({tag, "_tok_offset"}, tok_offset, 0);
    chk({tag, "_tok_len"},    tok_len, 0);
    chk({tag, "_tok_char"},   tok_char, 0);
  endtask

  initial begin
    string s20;
    reset = 1'b0; start = 1'b0; tok_ready = 1'b1;
    in_valid = 1'b0; in_char = 8'h00; in_last = 1'b0;
    @(posedge clk);
    #1;
    check_zero("rst");
    reset = 1'b1;
    tick();

    // "AAAA": overlap match of length 2 at offset 0
    exp_q.push_back(tk(0, 0, "A"));
    exp_q.push_back(tk(0, 2, "A"));
    load("AAAA");
    start_string();
    wait_done("aaaa", 200);

    // "ABCABCD": repeat found at offset 2
    exp_q.push_back(tk(0, 0, "A"));
    exp_q.push_back(tk(0, 0, "B"));
    exp_q.push_back(tk(0, 0, "C"));
    exp_q.push_back(tk(2, 3, "D"));
    load("ABCABCD");
    start_string();
    wait_done("abc", 300);

    // 20 x 'A': capped matches, window saturates
    s20 = "";
    for (int i = 0; i < 20; i++) s20 = {s20, "A"};
    exp_q.push_back(tk(0, 0, "A"));
    exp_q.push_back(tk(0, 7, "A"));
    exp_q.push_back(tk(0, 7, "A"));
    exp_q.push_back(tk(0, 2, "A"));
    load(s20);
    start_string();
    wait_done("a20", 500);
    chk("a20_tok2_latency", (gaps.size() > 1) ? gaps[1] : -1, EXP_GAP2);

    // "ABCABCD" with downstream back-pressure on token 4
    stall_on = 3; stall_rem = 5; stall_seen = 0;
    exp_q.push_back(tk(0, 0, "A"));
    exp_q.push_back(tk(0, 0, "B"));
    exp_q.push_back(tk(0, 0, "C"));
    exp_q.push_back(tk(2, 3, "D"));
    load("ABCABCD");
    start_string();
    wait_done("stall", 300);
    chk("stall_cycles", stall_seen, 5);
    stall_on = -1;

    // Reset during SEARCH of token 2, then a fresh "XY"
    exp_q.push_back(tk(0, 0, "A"));
    load("ABCABCD");
    start_string();
    for (int i = 0; i < 100 && tok_idx == 0; i++) tick();
    chk("abort_tok1_seen", tok_idx, 1);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_zero("midrst");
    chk("abort_no_done", done_cnt, 0);
    reset = 1'b1;
    src_q.delete();
    exp_q.delete();
    drive_inputs();
    tick();

    exp_q.push_back(tk(0, 0, "X"));
    exp_q.push_back(tk(0, 0, "Y"));
    load("XY");
    start_string();
    wait_done("xy", 200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
